ssd1306_spi_arbiter: RTL

SSD1306_SPI_ARBITER -- requirements
Module: ssd1306_spi_arbiter

---
 rtl/ssd1306_arb_pkg.sv | 26 ++
 rtl/ssd1306_spi_arbiter_if.sv | 41 ++++
 rtl/ssd1306_arb_timer.sv | 28 ++
 rtl/ssd1306_spi_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ssd1306_arb_pkg.sv
// Shared types and encodings for the SSD1306 SPI arbiter.
// Holds the FSM state enum, grant codes and D/C line levels.
package ssd1306_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SEND,
        WAIT
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CMD  = 2'b01;
    localparam logic [1:0] GNT_PIX  = 2'b10;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int TMR_W = 16;

    // Burst counter saturates instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ssd1306_spi_arbiter_if.sv
// Request/SPI bundle between the byte producers, the arbiter and the SPI master.
// The arbiter uses the slave modport; the producer side uses master.
interface ssd1306_spi_arbiter_if;

    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;

    logic       pix_valid;
    logic [7:0] pix_data;
    logic       pix_last;
    logic       pix_ready;

    logic [7:0] spi_data;
    logic       spi_wr;
    logic       spi_charreceived;

    logic       oled_dc;
    logic [1:0] grant;
    logic       busy;
    logic       timeout;

    modport master (
        output cmd_valid, cmd_data,
        output pix_valid, pix_data, pix_last,
        output spi_charreceived,
        input  cmd_ready, pix_ready,
        input  spi_data, spi_wr, oled_dc,
        input  grant, busy, timeout
    );

    modport slave (
        input  cmd_valid, cmd_data,
        input  pix_valid, pix_data, pix_last,
        input  spi_charreceived,
        output cmd_ready, pix_ready,
        output spi_data, spi_wr, oled_dc,
        output grant, busy, timeout
    );

endinterface

// File: rtl/ssd1306_arb_timer.sv
// Loadable down-counter; done is high while the count sits at one.
// Shared between D/C setup timing and the WAIT watchdog.
module ssd1306_arb_timer #(
    parameter int W = 16
) (
    input  logic         clk_50M,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == W'(1));

endmodule

// File: rtl/ssd1306_spi_arbiter.sv
// SSD1306 SPI arbiter: shares one SPI byte master between cmd and pixel streams.
// Define SSD1306_ARB_WATCHDOG_EN to add a WAIT-state watchdog (timeout pulse).
module ssd1306_spi_arbiter
    import ssd1306_arb_pkg::*;
#(
    parameter int DC_SETUP_CYCLES = 4,
    parameter int BURST_MAX       = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input logic                  clk_50M,
    input logic                  rst,
    ssd1306_spi_arbiter_if.slave bus
);

    if (DC_SETUP_CYCLES < 1 || DC_SETUP_CYCLES > 255) begin : g_bad_setup
        $error("DC_SETUP_CYCLES must be 1..255");
    end
    if (BURST_MAX < 1 || BURST_MAX > 255) begin : g_bad_burst
        $error("BURST_MAX must be 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be 1..65535");
    end

    localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);

    arb_state_t state;

    logic       lock;
    logic [7:0] burst_cnt;
    logic [7:0] burst_nxt;

    logic [7:0] data_q;
    logic       wr_q;
    logic       dc_q;
    logic [1:0] gnt_q;

    logic       pix_win;
    logic       cmd_acc;
    logic       pix_acc;
    logic       acc;
    logic       acc_dc;
    logic [7:0] acc_data;
    logic       dc_change;
    logic       burst_end;

    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic             wd_fire;

    // A locked burst keeps pixels ahead of pending commands.
    always_comb begin
        pix_win   = bus.pix_valid && (lock || !bus.cmd_valid);
        cmd_acc   = !rst && (state == IDLE) && bus.cmd_valid && !pix_win;
        pix_acc   = !rst && (state == IDLE) && pix_win;
        acc       = cmd_acc || pix_acc;
        acc_dc    = pix_acc ? DC_DATA : DC_CMD;
        acc_data  = pix_acc ? bus.pix_data : bus.cmd_data;
        dc_change = (acc_dc != dc_q);
        burst_nxt = sat_inc(burst_cnt);
        burst_end = cmd_acc || bus.pix_last || (burst_nxt >= BURST_LIM);
    end

`ifdef SSD1306_ARB_WATCHDOG_EN
    assign wd_fire  = (state == WAIT) && tmr_done && !bus.spi_charreceived;
    assign tmr_load = (acc && dc_change) || (state == SEND);
    assign tmr_val  = (state == SEND) ? TMR_W'(TIMEOUT_CYCLES)
                                      : TMR_W'(DC_SETUP_CYCLES);
    assign tmr_en   = (state == SETUP) || (state == WAIT);
`else
    assign wd_fire  = 1'b0;
    assign tmr_load = acc && dc_change;
    assign tmr_val  = TMR_W'(DC_SETUP_CYCLES);
    assign tmr_en   = (state == SETUP);
`endif

    ssd1306_arb_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_50M  (clk_50M),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            data_q    <= 8'h00;
            dc_q      <= DC_CMD;
            gnt_q     <= GNT_NONE;
            lock      <= 1'b0;
            burst_cnt <= 8'd0;
        end else begin
            wr_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        data_q <= acc_data;
                        dc_q   <= acc_dc;
                        gnt_q  <= pix_acc ? GNT_PIX : GNT_CMD;
                        if (dc_change) begin
                            state <= SETUP;
                        end else begin
                            state <= SEND;
                            wr_q  <= 1'b1;
                        end
                        if (burst_end) begin
                            lock      <= 1'b0;
                            burst_cnt <= 8'd0;
                        end else begin
                            lock      <= 1'b1;
                            burst_cnt <= burst_nxt;
                        end
                    end
                end
                SETUP: begin
                    if (tmr_done) begin
                        state <= SEND;
                        wr_q  <= 1'b1;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.spi_charreceived) begin
                        state <= IDLE;
                        gnt_q <= GNT_NONE;
                    end else if (wd_fire) begin
                        state     <= IDLE;
                        gnt_q     <= GNT_NONE;
                        lock      <= 1'b0;
                        burst_cnt <= 8'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = cmd_acc;
    assign bus.pix_ready = pix_acc;
    assign bus.spi_data  = data_q;
    assign bus.spi_wr    = wr_q;
    assign bus.oled_dc   = dc_q;
    assign bus.grant     = gnt_q;
    assign bus.busy      = (state != IDLE);
    assign bus.timeout   = wd_fire;

endmodule
